// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: front-end sequencer for a single-port RAM with a 1-cycle registered read.
//   Arbitrates one write port and one read port (valid/ready) onto the RAM's single address
//   bus. Fill requests win over writes, and writes win over reads. The block returns read data
//   with a strobe one cycle after acceptance. A fill engine writes one value to every address.
//
// Ports:
//   clk_i, reset_ni        clock (rising edge), synchronous active-low reset
//   fill_start_i/value_i   fill request pulse and fill word (sampled on acceptance)
//   fill_busy_o/done_o     fill running / 1-cycle pulse after the last fill write
//   wr_valid_i/ready_o     write handshake; wr_addr_i, wr_data_i
//   rd_valid_i/ready_o     read handshake; rd_addr_i
//   rd_data_valid_o/data_o read return, one cycle after acceptance
//   ram_write_o/addr_o/data_in_o, ram_data_out_i  RAM interface
module ram_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDRESSES  = 1024,
    localparam int unsigned AW = (ADDRESSES > 1) ? $clog2(ADDRESSES) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  fill_start_i,
    input  logic [DATA_WIDTH-1:0] fill_value_i,
    output logic                  fill_busy_o,
    output logic                  fill_done_o,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [AW-1:0]         rd_addr_i,
    output logic                  rd_data_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  ram_write_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_in_o,
    input  logic [DATA_WIDTH-1:0] ram_data_out_i
);

    localparam logic [AW-1:0] LastAddr = AW'(ADDRESSES - 1);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                state_q;
    logic [AW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] fill_val_q;
    logic                  fill_busy_q;
    logic                  fill_done_q;
    logic                  rd_data_valid_q;

    logic idle;
    logic wr_acc;
    logic rd_acc;

    always_comb begin
        idle       = (state_q == StIdle);
        wr_ready_o = idle && !fill_start_i;
        rd_ready_o = idle && !fill_start_i && !wr_valid_i;
        wr_acc     = wr_valid_i && wr_ready_o;
        rd_acc     = rd_valid_i && rd_ready_o;

        // Default routing keeps the read address on the bus so an idle RAM simply re-reads.
        ram_write_o   = wr_acc;
        ram_addr_o    = wr_acc ? wr_addr_i : rd_addr_i;
        ram_data_in_o = wr_data_i;
        if (!idle) begin
            ram_write_o   = 1'b1;
            ram_addr_o    = cnt_q;
            ram_data_in_o = fill_val_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            fill_busy_q     <= 1'b0;
            fill_done_q     <= 1'b0;
            rd_data_valid_q <= 1'b0;
        end else begin
            rd_data_valid_q <= rd_acc;
            fill_done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fill_start_i) begin
                        fill_val_q  <= fill_value_i;
                        cnt_q       <= '0;
                        fill_busy_q <= 1'b1;
                        state_q     <= StFill;
                    end
                end
                StFill: begin
                    // The last address is written this cycle; the counter never passes it.
                    if (cnt_q == LastAddr) begin
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fill_busy_o     = fill_busy_q;
    assign fill_done_o     = fill_done_q;
    assign rd_data_valid_o = rd_data_valid_q;
    assign rd_data_o       = ram_data_out_i;

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;

    logic          clk_i = 1'b0;
    logic          reset_ni;
    logic          fill_start_i;
    logic [DW-1:0] fill_value_i;
    logic          fill_busy_o, fill_done_o;
    logic          wr_valid_i, wr_ready_o;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          rd_valid_i, rd_ready_o;
    logic [AW-1:0] rd_addr_i;
    logic          rd_data_valid_o;
    logic [DW-1:0] rd_data_o;
    logic          ram_write_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_in_o;
    logic [DW-1:0] ram_data_out_i;

    logic [DW-1:0] ram [N];
    logic [DW-1:0] ref_mem [N];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    // Single-port RAM with registered read, as seen by the controller.
    always @(posedge clk_i) begin
        if (ram_write_o) ram[ram_addr_o] <= ram_data_in_o;
        ram_data_out_i <= ram[ram_addr_o];
    end

    ram_access_ctrl #(.DATA_WIDTH(DW), .ADDRESSES(N)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .fill_start_i   (fill_start_i),
        .fill_value_i   (fill_value_i),
        .fill_busy_o    (fill_busy_o),
        .fill_done_o    (fill_done_o),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .rd_valid_i     (rd_valid_i),
        .rd_ready_o     (rd_ready_o),
        .rd_addr_i      (rd_addr_i),
        .rd_data_valid_o(rd_data_valid_o),
        .rd_data_o      (rd_data_o),
        .ram_write_o    (ram_write_o),
        .ram_addr_o     (ram_addr_o),
        .ram_data_in_o  (ram_data_in_o),
        .ram_data_out_i (ram_data_out_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        #1;
        chk("wr_ready", wr_ready_o, 1);
        chk("wr_ram_write", ram_write_o, 1);
        chk("wr_ram_addr", ram_addr_o, a);
        chk("wr_ram_data", ram_data_in_o, d);
        step();
        wr_valid_i = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_valid_i = 1'b1;
        rd_addr_i  = a;
        #1;
        chk("rd_ready", rd_ready_o, 1);
        chk("rd_ram_write", ram_write_o, 0);
        chk("rd_ram_addr", ram_addr_o, a);
        step();
        rd_valid_i = 1'b0;
        chk("rd_valid", rd_data_valid_o, 1);
        chk("rd_data", rd_data_o, ref_mem[a]);
    endtask

    // Fill of N cycles already started (fill_start accepted at the previous edge).
    task automatic run_fill(input logic [DW-1:0] v, input bit poke);
        int dones = 0;
        for (int i = 0; i < N; i++) begin
            fill_start_i = poke && (i == 7);
            fill_value_i = poke ? 8'h99 : v;
            #1;
            chk("fill_busy", fill_busy_o, 1);
            chk("fill_wr_ready", wr_ready_o, 0);
            chk("fill_rd_ready", rd_ready_o, 0);
            chk("fill_ram_write", ram_write_o, 1);
            chk("fill_ram_addr", ram_addr_o, i);
            chk("fill_ram_data", ram_data_in_o, v);
            if (fill_done_o) dones++;
            step();
        end
        fill_start_i = 1'b0;
        chk("fill_done_once", dones, 0);
        chk("fill_busy_end", fill_busy_o, 0);
        chk("fill_done_pulse", fill_done_o, 1);
        for (int i = 0; i < N; i++) ref_mem[i] = v;
    endtask

    initial begin
        logic          wv, rv, exp_v;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, exp_d;

        reset_ni = 1'b0; fill_start_i = 1'b0; fill_value_i = '0;
        wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        rd_valid_i = 1'b0; rd_addr_i = '0;
        step(); step();
        chk("rst_fill_busy", fill_busy_o, 0);
        chk("rst_fill_done", fill_done_o, 0);
        chk("rst_rd_valid", rd_data_valid_o, 0);
        reset_ni = 1'b1;
        #1;
        chk("idle_ram_write", ram_write_o, 0);

        // 1: write then read back
        do_write(4'd3, 8'hA5);
        do_read(4'd3);
        step();
        chk("rd_valid_drops", rd_data_valid_o, 0);

        // 2: four writes, streamed reads
        for (int i = 0; i < 4; i++) do_write(AW'(i), DW'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            rd_valid_i = 1'b1;
            rd_addr_i  = AW'(i);
            step();
            chk("stream_valid", rd_data_valid_o, 1);
            chk("stream_data", rd_data_o, 8'h10 + i);
        end
        rd_valid_i = 1'b0;

        // 3: simultaneous write and read to the same address
        wr_valid_i = 1'b1; wr_addr_i = 4'd5; wr_data_i = 8'h77;
        rd_valid_i = 1'b1; rd_addr_i = 4'd5;
        #1;
        chk("both_wr_ready", wr_ready_o, 1);
        chk("both_rd_ready", rd_ready_o, 0);
        chk("both_ram_write", ram_write_o, 1);
        step();
        wr_valid_i = 1'b0;
        chk("both_no_rd_valid", rd_data_valid_o, 0);
        #1;
        chk("both_rd_ready2", rd_ready_o, 1);
        step();
        rd_valid_i = 1'b0;
        chk("raw_valid", rd_data_valid_o, 1);
        chk("raw_data", rd_data_o, 8'h77);

        // 4: fill with 0x3C, mid-fill fill_start ignored
        fill_start_i = 1'b1; fill_value_i = 8'h3C;
        #1;
        chk("fs_wr_ready", wr_ready_o, 0);
        chk("fs_rd_ready", rd_ready_o, 0);
        chk("fs_no_access", ram_write_o, 0);
        step();
        run_fill(8'h3C, 1'b1);
        step();
        chk("fill_done_clear", fill_done_o, 0);
        for (int i = 0; i < N; i++) do_read(AW'(i));

        // Random traffic against the array model
        for (int n = 0; n < 60; n++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, N - 1));
            ra = AW'($urandom_range(0, N - 1));
            wd = DW'($urandom);
            wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd;
            rd_valid_i = rv; rd_addr_i = ra;
            #1;
            chk("rnd_wr_ready", wr_ready_o, 1);
            chk("rnd_rd_ready", rd_ready_o, !wv);
            chk("rnd_ram_write", ram_write_o, wv);
            exp_v = rv && !wv;
            exp_d = ref_mem[ra];
            if (wv) ref_mem[wa] = wd;
            step();
            chk("rnd_rd_valid", rd_data_valid_o, exp_v);
            if (exp_v) chk("rnd_rd_data", rd_data_o, exp_d);
        end
        wr_valid_i = 1'b0; rd_valid_i = 1'b0;
        step();

        // 6: read before fill_start; fill_start and wr_valid together
        rd_valid_i = 1'b1; rd_addr_i = 4'd4;
        step();
        rd_valid_i = 1'b0;
        fill_start_i = 1'b1; fill_value_i = 8'h00;
        wr_valid_i = 1'b1; wr_addr_i = 4'd9; wr_data_i = 8'h42;
        #1;
        chk("pre_fill_rd_valid", rd_data_valid_o, 1);
        chk("pre_fill_rd_data", rd_data_o, ref_mem[4]);
        chk("fs_wr_blocked", wr_ready_o, 0);
        chk("fs_wr_no_write", ram_write_o, 0);
        step();
        run_fill(8'h00, 1'b0);
        chk("post_fill_wr_ready", wr_ready_o, 1);
        step();
        wr_valid_i = 1'b0;
        ref_mem[9] = 8'h42;
        do_read(4'd9);
        do_read(4'd8);

        // 5: reset at fill cycle 6
        fill_start_i = 1'b1; fill_value_i = 8'hFF;
        step();
        fill_start_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_fill_addr", ram_addr_o, 6);
        reset_ni = 1'b0;
        step();
        reset_ni = 1'b1;
        chk("abort_busy", fill_busy_o, 0);
        chk("abort_rd_valid", rd_data_valid_o, 0);
        chk("abort_done", fill_done_o, 0);
        #1;
        chk("abort_idle", wr_ready_o, 1);
        do_write(4'd2, 8'h5A);
        do_read(4'd2);

        // Pending read return dropped by reset
        rd_valid_i = 1'b1; rd_addr_i = 4'd2; reset_ni = 1'b0;
        step();
        rd_valid_i = 1'b0; reset_ni = 1'b1;
        chk("rst_drops_rd_valid", rd_data_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
